// File: rtl/mem_arb_pkg.sv
// Shared definitions for the L2 main-memory arbiter.
//   - FSM state encoding (IDLE/BUSY/RESP)
//   - side encoding (I = instruction-miss channel, D = data channel)
//   - request opcode encoding and default widths
//   - debug bundle exposing FSM state, current winner and duplicate-pulse flag
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 28;
  localparam int DATA_W_DEF       = 128;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    arb_state_t state;
    side_t      win;
    logic       err_dup;
  } arb_dbg_t;

endpackage

// File: rtl/req_buffer.sv
// One-entry request capture register for one side of the arbiter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   set             request pulse; captures op/addr/wdata when the entry is free
//   set_op          OP_READ / OP_WRITE
//   set_addr        block address
//   set_wdata       write data
//   clr             entry has been served
//   valid/op/addr/wdata  captured request
//   dup             pulse arrived while the entry was still occupied (dropped)
module req_buffer
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              set_op,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [DATA_W-1:0] set_wdata,
  input  logic              clr,
  output logic              valid,
  output logic              op,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              dup
);

  // A pulse arriving in the same cycle the entry is served is accepted:
  // the entry is being freed at this very edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      op    <= OP_READ;
      addr  <= '0;
      wdata <= '0;
    end else if (set && (!valid || clr)) begin
      valid <= 1'b1;
      op    <= set_op;
      addr  <= set_addr;
      wdata <= set_wdata;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  assign dup = set && valid && !clr;

endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares one main-memory port between the L2 instruction-miss read channel (I)
// and the L2 data channel (D: refill reads and dirty write-backs).
// Request pulses are captured into one-entry buffers per side; the FSM
// (IDLE -> BUSY -> RESP) issues one block transfer at a time, holds the
// command until mem_ready, then pulses the winner's mem_ready_X for one cycle.
//
// Configuration macro: ARB_RR_EN
//   defined   : round-robin between sides via a one-bit last-grant pointer
//   undefined : fixed D-over-I priority with a starvation counter (STARVE_LIMIT)
//   In both modes a pending D write to the same address as a pending I read
//   is granted first so the read observes the written-back block.
//
// Ports:
//   clk, proc_reset                  clock, asynchronous active-high reset
//   mem_read_I, mem_addr_I           I read request pulse + address
//   mem_rdata_I, mem_ready_I         I read data, completion pulse
//   mem_read_D, mem_write_D          D request pulses (write wins if both)
//   mem_addr_D, mem_wdata_D          D address and write data
//   mem_rdata_D, mem_ready_D         D read data, completion pulse
//   mem_read, mem_write, mem_addr,
//   mem_wdata                        command to memory, stable until mem_ready
//   mem_rdata, mem_ready             memory response
//   dbg                              FSM state, current winner, dup-pulse flag
//
// Handshake: every request is a single-cycle pulse with its address/data valid
// in that cycle; the memory command is held until mem_ready is sampled high in
// BUSY, and completion back to L2 is a single-cycle mem_ready_X pulse.
module l2_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              mem_read_I,
  input  logic [ADDR_W-1:0] mem_addr_I,
  output logic [DATA_W-1:0] mem_rdata_I,
  output logic              mem_ready_I,
  input  logic              mem_read_D,
  input  logic              mem_write_D,
  input  logic [ADDR_W-1:0] mem_addr_D,
  input  logic [DATA_W-1:0] mem_wdata_D,
  output logic [DATA_W-1:0] mem_rdata_D,
  output logic              mem_ready_D,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output arb_dbg_t          dbg
);

  arb_state_t state, state_n;
  side_t      win;
  side_t      pick;
  logic       hazard;
  logic       done;
  logic       err_dup;

  logic              i_valid, i_op, i_dup;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              d_valid, d_op, d_dup;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;

  // Transfer completes at the edge where mem_ready is seen in BUSY.
  assign done = (state == BUSY) && mem_ready;

  req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_i (
    .clk       (clk),
    .rst       (proc_reset),
    .set       (mem_read_I),
    .set_op    (OP_READ),
    .set_addr  (mem_addr_I),
    .set_wdata ('0),
    .clr       (done && (win == SIDE_I)),
    .valid     (i_valid),
    .op        (i_op),
    .addr      (i_addr),
    .wdata     (i_wdata),
    .dup       (i_dup)
  );

  req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_d (
    .clk       (clk),
    .rst       (proc_reset),
    .set       (mem_read_D || mem_write_D),
    .set_op    (mem_write_D ? OP_WRITE : OP_READ),
    .set_addr  (mem_addr_D),
    .set_wdata (mem_wdata_D),
    .clr       (done && (win == SIDE_D)),
    .valid     (d_valid),
    .op        (d_op),
    .addr      (d_addr),
    .wdata     (d_wdata),
    .dup       (d_dup)
  );

  assign hazard = d_valid && (d_op == OP_WRITE) &&
                  i_valid && (i_op == OP_READ) && (d_addr == i_addr);

`ifdef ARB_RR_EN
  side_t last_grant;

  always_comb begin
    pick = SIDE_D;
    if (!i_valid)      pick = SIDE_D;
    else if (!d_valid) pick = SIDE_I;
    else if (hazard)   pick = SIDE_D;
    else               pick = (last_grant == SIDE_D) ? SIDE_I : SIDE_D;
  end

  // Reset value SIDE_D makes the first contested grant go to I.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      last_grant <= SIDE_D;
    end else if (state == IDLE && (i_valid || d_valid)) begin
      last_grant <= pick;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    pick = SIDE_D;
    if (!i_valid)                               pick = SIDE_D;
    else if (!d_valid)                          pick = SIDE_I;
    else if (hazard)                            pick = SIDE_D;
    else if (starve_cnt >= CNT_W'(STARVE_LIMIT)) pick = SIDE_I;
    else                                        pick = SIDE_D;
  end

  // Counts D grants made while I waits; saturates at the limit.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && (i_valid || d_valid)) begin
      if (pick == SIDE_I) begin
        starve_cnt <= '0;
      end else if (i_valid && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_valid || d_valid) state_n = BUSY;
      BUSY:    if (mem_ready)          state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state       <= IDLE;
      win         <= SIDE_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rdata_I <= '0;
      mem_rdata_D <= '0;
      mem_ready_I <= 1'b0;
      mem_ready_D <= 1'b0;
      err_dup     <= 1'b0;
    end else begin
      state       <= state_n;
      mem_ready_I <= 1'b0;
      mem_ready_D <= 1'b0;
      err_dup     <= i_dup || d_dup;
      case (state)
        IDLE: begin
          if (i_valid || d_valid) begin
            win <= pick;
            if (pick == SIDE_D) begin
              mem_read  <= (d_op == OP_READ);
              mem_write <= (d_op == OP_WRITE);
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= i_wdata;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (win == SIDE_I) begin
              mem_rdata_I <= mem_rdata;
              mem_ready_I <= 1'b1;
            end else begin
              // Write-backs leave the D read-data register untouched.
              if (!mem_write) mem_rdata_D <= mem_rdata;
              mem_ready_D <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg.state   = state;
  assign dbg.win     = win;
  assign dbg.err_dup = err_dup;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter: directed scenarios, a memory
// responder with configurable latency, an expected-command queue and
// completion counters. Expectations follow ARB_RR_EN when it is defined.
module tb_l2_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  // clock / reset
  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  logic              mem_read_I, mem_ready_I;
  logic [ADDR_W-1:0] mem_addr_I;
  logic [DATA_W-1:0] mem_rdata_I;
  logic              mem_read_D, mem_write_D, mem_ready_D;
  logic [ADDR_W-1:0] mem_addr_D;
  logic [DATA_W-1:0] mem_wdata_D, mem_rdata_D;
  logic              mem_read, mem_write, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  arb_dbg_t          dbg;

  l2_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .mem_read_I  (mem_read_I),
    .mem_addr_I  (mem_addr_I),
    .mem_rdata_I (mem_rdata_I),
    .mem_ready_I (mem_ready_I),
    .mem_read_D  (mem_read_D),
    .mem_write_D (mem_write_D),
    .mem_addr_D  (mem_addr_D),
    .mem_wdata_D (mem_wdata_D),
    .mem_rdata_D (mem_rdata_D),
    .mem_ready_D (mem_ready_D),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .dbg         (dbg)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [ADDR_W:0]   exp_q[$];     // {is_write, addr}
  logic [DATA_W-1:0] exp_wd_q[$];
  logic              served_q[$];  // order of completions (SIDE_I/SIDE_D)
  int rdy_i_cnt = 0;
  int rdy_d_cnt = 0;
  int mem_lat   = 5;

  localparam logic [DATA_W-1:0] WR_JUNK = {4{32'hDEADBEEF}};

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] resp_of(input logic [ADDR_W-1:0] a);
    return {16{a[7:0] ^ 8'hB5}};
  endfunction

  task automatic expect_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd);
    exp_q.push_back({wr, a});
    exp_wd_q.push_back(wd);
  endtask

  // memory responder: checks each command against the expected queue,
  // checks it stays stable, then answers after mem_lat cycles
  logic [1:0]        cur_rw;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wd, exp_wd;
  logic [ADDR_W:0]   exp_cmd;
  logic              aborted;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        cur_rw   = {mem_read, mem_write};
        cur_addr = mem_addr;
        cur_wd   = mem_wdata;
        check_val("cmd_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_cmd = exp_q.pop_front();
          exp_wd  = exp_wd_q.pop_front();
          check_val("cmd_op_addr", {mem_write, mem_addr}, exp_cmd);
          if (mem_write) check_val("cmd_wdata", mem_wdata, exp_wd);
        end
        check_val("cmd_onehot", mem_read & mem_write, 0);
        aborted = 1'b0;
        for (int k = 1; k < mem_lat; k++) begin
          @(negedge clk);
          if (!(mem_read || mem_write)) begin
            aborted = 1'b1;
            break;
          end
          check_val("cmd_stable_addr", {mem_read, mem_write, mem_addr}, {cur_rw, cur_addr});
          check_val("cmd_stable_wdata", mem_wdata, cur_wd);
        end
        if (!aborted) begin
          mem_rdata = cur_rw[0] ? WR_JUNK : resp_of(cur_addr);
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
          check_val("cmd_drop", mem_read | mem_write, 0);
        end
      end
    end
  end

  // completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mem_ready_I) begin rdy_i_cnt++; served_q.push_back(SIDE_I); end
      if (mem_ready_D) begin rdy_d_cnt++; served_q.push_back(SIDE_D); end
    end
  end

  // driver tasks
  task automatic do_reset();
    proc_reset  = 1'b1;
    mem_read_I  = 1'b0;
    mem_addr_I  = '0;
    mem_read_D  = 1'b0;
    mem_write_D = 1'b0;
    mem_addr_D  = '0;
    mem_wdata_D = '0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    exp_q.delete();
    exp_wd_q.delete();
    served_q.delete();
    rdy_i_cnt = 0;
    rdy_d_cnt = 0;
  endtask

  task automatic pulse(input logic ri, input logic [ADDR_W-1:0] ai,
                       input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
    @(posedge clk); #1;
    mem_read_I  = ri;
    mem_addr_I  = ai;
    mem_read_D  = rd;
    mem_write_D = wr;
    mem_addr_D  = ad;
    mem_wdata_D = wd;
    @(posedge clk); #1;
    mem_read_I  = 1'b0;
    mem_read_D  = 1'b0;
    mem_write_D = 1'b0;
  endtask

  task automatic wait_done(input int n_i, input int n_d, input int budget);
    int c = 0;
    while ((rdy_i_cnt < n_i || rdy_d_cnt < n_d) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val("wait_timeout", c < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_order(input logic [7:0] seq, input int n);
    check_val("served_cnt", served_q.size(), n);
    for (int i = 0; i < n && i < served_q.size(); i++)
      check_val("served_order", served_q[i], seq[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    int d_sent;

    // reset state
    do_reset();
    @(negedge clk);
    check_val("rst_mem_read", mem_read, 0);
    check_val("rst_mem_write", mem_write, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_ready_I", mem_ready_I, 0);
    check_val("rst_ready_D", mem_ready_D, 0);
    check_val("rst_rdata_I", mem_rdata_I, 0);
    check_val("rst_state", dbg.state, IDLE);

    // lone I read, command visible two cycles after the pulse
    do_reset();
    mem_lat = 5;
    expect_cmd(1'b0, 28'h10, '0);
    @(posedge clk); #1;
    mem_read_I = 1'b1;
    mem_addr_I = 28'h10;
    @(negedge clk);
    check_val("t1_cyc0_read", mem_read, 0);
    @(posedge clk); #1;
    mem_read_I = 1'b0;
    @(negedge clk);
    check_val("t1_cyc1_read", mem_read, 0);
    check_val("t1_cyc1_state", dbg.state, IDLE);
    @(negedge clk);
    check_val("t1_cyc2_read", mem_read, 1);
    check_val("t1_cyc2_addr", mem_addr, 28'h10);
    check_val("t1_cyc2_state", dbg.state, BUSY);
    wait_done(1, 0, 50);
    check_val("t1_rdata_I", mem_rdata_I, {16{8'hA5}});
    check_val("t1_rdy_i_cnt", rdy_i_cnt, 1);
    check_val("t1_rdy_d_cnt", rdy_d_cnt, 0);
    check_val("t1_q_empty", exp_q.size(), 0);

    // simultaneous I read 0x20 and D read 0x40
    do_reset();
    mem_lat = 3;
`ifdef ARB_RR_EN
    expect_cmd(1'b0, 28'h20, '0);
    expect_cmd(1'b0, 28'h40, '0);
`else
    expect_cmd(1'b0, 28'h40, '0);
    expect_cmd(1'b0, 28'h20, '0);
`endif
    pulse(1'b1, 28'h20, 1'b1, 1'b0, 28'h40, '0);
    wait_done(1, 1, 80);
`ifdef ARB_RR_EN
    check_order(8'b10, 2);
`else
    check_order(8'b01, 2);
`endif
    check_val("t2_rdata_I", mem_rdata_I, resp_of(28'h20));
    check_val("t2_rdata_D", mem_rdata_D, resp_of(28'h40));
    check_val("t2_q_empty", exp_q.size(), 0);

    // D write 0x33 (read+write pulsed together, write wins) vs I read 0x33
    do_reset();
    mem_lat = 3;
    expect_cmd(1'b1, 28'h33, 128'h1234);
    expect_cmd(1'b0, 28'h33, '0);
    pulse(1'b1, 28'h33, 1'b1, 1'b1, 28'h33, 128'h1234);
    wait_done(1, 1, 80);
    check_order(8'b01, 2);
    check_val("t3_rdata_I", mem_rdata_I, resp_of(28'h33));
    check_val("t3_rdata_D_kept", mem_rdata_D, 0);
    check_val("t3_q_empty", exp_q.size(), 0);

    // continuous D traffic with I pending
    do_reset();
    mem_lat = 2;
`ifdef ARB_RR_EN
    expect_cmd(1'b0, 28'h50, '0);
    for (int k = 0; k < 5; k++) expect_cmd(1'b0, 28'h60 + 28'(k), '0);
`else
    for (int k = 0; k < 4; k++) expect_cmd(1'b0, 28'h60 + 28'(k), '0);
    expect_cmd(1'b0, 28'h50, '0);
    expect_cmd(1'b0, 28'h64, '0);
`endif
    pulse(1'b1, 28'h50, 1'b1, 1'b0, 28'h60, '0);
    d_sent = 1;
    c = 0;
    while ((rdy_d_cnt < 5 || rdy_i_cnt < 1) && c < 600) begin
      @(negedge clk);
      c++;
      mem_read_D = 1'b0;
      if (mem_ready_D && d_sent < 5) begin
        mem_addr_D = 28'h60 + 28'(d_sent);
        mem_read_D = 1'b1;
        d_sent++;
      end
    end
    check_val("t4_timeout", c < 600, 1);
    repeat (3) @(negedge clk);
`ifdef ARB_RR_EN
    check_order(8'b111110, 6);
`else
    check_order(8'b101111, 6);
`endif
    check_val("t4_rdata_I", mem_rdata_I, resp_of(28'h50));
    check_val("t4_rdata_D", mem_rdata_D, resp_of(28'h64));
    check_val("t4_q_empty", exp_q.size(), 0);

    // reset in the middle of BUSY
    do_reset();
    mem_lat = 10;
    expect_cmd(1'b0, 28'h70, '0);
    pulse(1'b1, 28'h70, 1'b0, 1'b0, '0, '0);
    c = 0;
    while (!mem_read && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_val("t5_cmd_seen", mem_read, 1);
    repeat (2) @(negedge clk);
    #1 proc_reset = 1'b1;
    #1;
    check_val("t5_async_read", mem_read, 0);
    check_val("t5_async_write", mem_write, 0);
    check_val("t5_async_state", dbg.state, IDLE);
    @(posedge clk);
    @(posedge clk);
    #1 proc_reset = 1'b0;
    repeat (8) @(negedge clk);
    check_val("t5_no_reissue", mem_read, 0);
    check_val("t5_no_ready_I", rdy_i_cnt, 0);
    check_val("t5_no_ready_D", rdy_d_cnt, 0);
    mem_lat = 3;
    expect_cmd(1'b0, 28'h74, '0);
    pulse(1'b1, 28'h74, 1'b0, 1'b0, '0, '0);
    wait_done(1, 0, 50);
    check_val("t5_rdata_I", mem_rdata_I, resp_of(28'h74));
    check_val("t5_rdy_i_cnt", rdy_i_cnt, 1);
    check_val("t5_q_empty", exp_q.size(), 0);

    // duplicate I pulse while I is pending
    do_reset();
    mem_lat = 6;
    expect_cmd(1'b0, 28'h90, '0);
    pulse(1'b1, 28'h90, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    mem_read_I = 1'b1;
    mem_addr_I = 28'h94;
    @(posedge clk); #1;
    mem_read_I = 1'b0;
    @(negedge clk);
    check_val("t6_err_dup", dbg.err_dup, 1);
    wait_done(1, 0, 60);
    repeat (10) @(negedge clk);
    check_val("t6_rdy_i_cnt", rdy_i_cnt, 1);
    check_val("t6_rdata_I", mem_rdata_I, resp_of(28'h90));
    check_val("t6_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
